// File: rtl/fetch_bpred.sv
// Fetch stage with a direct-mapped branch target buffer.
// Holds the PC, talks to instruction memory, and feeds the Fetch->Decode register.
// Branches resolved in Execute train the BTB, redirect the PC on a mispredict,
// and update saturating statistics counters.
module fetch_bpred #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned IADDR       = 10,
   parameter int unsigned BTB_ENTRIES = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] init_pc,
   output logic [IADDR-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             stall_d,
   output logic             d_valid,
   output logic [WIDTH-1:0] d_instr,
   output logic [WIDTH-1:0] d_pc,
   output logic [WIDTH-1:0] d_inc_pc,
   output logic             d_pred_taken,
   output logic [WIDTH-1:0] d_pred_target,
   input  logic             ex_br_valid,
   input  logic [WIDTH-1:0] ex_pc,
   input  logic             ex_pred_taken,
   input  logic [WIDTH-1:0] ex_pred_target,
   input  logic             ex_taken,
   input  logic [WIDTH-1:0] ex_target,
   output logic             flush_d,
   output logic             flush_e,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mispred_count
);

   localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = WIDTH - IDX_W - 2;

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] inc_pc;
   logic [WIDTH-1:0] redirect_pc;
   logic             mispredict;

   // BTB storage
   logic             btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
   logic [WIDTH-1:0] btb_target [BTB_ENTRIES];
   logic [1:0]       btb_cnt    [BTB_ENTRIES];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic             pred_taken;
   logic [WIDTH-1:0] pred_target;

   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;

   assign imem_addr = pc_q[IADDR-1:0];
   assign inc_pc    = pc_q + WIDTH'(4);

   // Mispredict detection and redirect target from Execute
   always_comb begin
      mispredict = ex_br_valid &
                   ((ex_taken != ex_pred_taken) |
                    (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
      redirect_pc = ex_taken ? ex_target : (ex_pc + WIDTH'(4));
   end

   assign flush_d = mispredict;
   assign flush_e = mispredict;

   // BTB lookup on the current PC and hit check for the resolving branch
   always_comb begin
      f_idx       = pc_q[IDX_W+1:2];
      f_tag       = pc_q[WIDTH-1:IDX_W+2];
      f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      pred_taken  = f_hit && btb_cnt[f_idx][1];
      pred_target = f_hit ? btb_target[f_idx] : '0;
      ex_idx      = ex_pc[IDX_W+1:2];
      ex_tag      = ex_pc[WIDTH-1:IDX_W+2];
      ex_hit      = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
   end

   // Next-PC selection: redirect beats stall, stall beats prediction
   always_comb begin
      pc_d = inc_pc;
      if (mispredict) begin
         pc_d = redirect_pc;
      end else if (stall_d || !imem_ready) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = pred_target;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= init_pc;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Fetch->Decode register; a flush wins over a stall
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_valid       <= 1'b0;
         d_instr       <= '0;
         d_pc          <= '0;
         d_inc_pc      <= '0;
         d_pred_taken  <= 1'b0;
         d_pred_target <= '0;
      end else if (mispredict) begin
         d_valid <= 1'b0;
      end else if (stall_d) begin
         d_valid <= d_valid;
      end else if (!imem_ready) begin
         d_valid <= 1'b0;
      end else begin
         d_valid       <= 1'b1;
         d_instr       <= imem_rdata;
         d_pc          <= pc_q;
         d_inc_pc      <= inc_pc;
         d_pred_taken  <= pred_taken;
         d_pred_target <= pred_target;
      end
   end

   // BTB training; lookups this cycle still see the old entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_cnt[i]    <= 2'b01;
         end
      end else if (ex_br_valid) begin
         if (ex_hit) begin
            if (ex_taken) begin
               if (btb_cnt[ex_idx] != 2'b11) btb_cnt[ex_idx] <= btb_cnt[ex_idx] + 2'b01;
               btb_target[ex_idx] <= ex_target;
            end else if (btb_cnt[ex_idx] != 2'b00) begin
               btb_cnt[ex_idx] <= btb_cnt[ex_idx] - 2'b01;
            end
         end else if (ex_taken) begin
            btb_valid[ex_idx]  <= 1'b1;
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= ex_target;
            btb_cnt[ex_idx]    <= 2'b10;
         end
      end
   end

   // Saturating branch and mispredict statistics
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         if (ex_br_valid && (br_count != '1)) br_count <= br_count + CNT_W'(1);
         if (mispredict && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
      end
   end

endmodule
